spi_pixel_sender: RTL

//  Upstream feeder for the display controller's SPI pixel input. Accepts 16-bit RGB565 pixels

---
 rtl/ili9341_pkg.sv | 22 ++
 rtl/spi_pixel_sender_if.sv | 23 ++
 rtl/spi_bit_timer.sv | 40 ++++
 rtl/spi_pixel_sender.sv | 116 +++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 display path: pixel/display geometry and the
// SPI pixel sender state encoding.
package ili9341_pkg;

    localparam int PIXEL_W   = 16;
    localparam int DISP_W    = 240;
    localparam int DISP_H    = 320;
    localparam int PIX_IDX_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SHIFT,
        ST_GAP
    } spi_sender_state_t;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_pixel_sender_if.sv
// Pixel handshake plus SPI link of the pixel sender. The master side offers pixels and
// drives spi_ready; the slave side is the sender itself.
interface spi_pixel_sender_if;
    import ili9341_pkg::*;

    logic               pix_valid;
    logic [PIXEL_W-1:0] pix_data;
    logic               pix_ready;
    logic               spi_ready;
    logic               spi_sck;
    logic               spi_sda;

    modport master (
        output pix_valid, pix_data, spi_ready,
        input  pix_ready, spi_sck, spi_sda
    );

    modport slave (
        input  pix_valid, pix_data, spi_ready,
        output pix_ready, spi_sck, spi_sda
    );

endinterface

// File: rtl/spi_bit_timer.sv
// SCK half-period timer: while enabled, emits alternating rise/fall strobes every CLK_DIV
// clk cycles, first a rise; held cleared while disabled.
module spi_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sck_rise,
    output logic sck_fall
);

    localparam int               CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             tick;

    assign tick     = en && (cnt == LAST);
    assign sck_rise = tick && !phase;
    assign sck_fall = tick && phase;

    // NOTE: non-blocking assignments so every flop here samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_pixel_sender.sv
// Serializes RGB565 pixels MSB-first onto spi_sck/spi_sda, starting a word only while
// spi_ready is high. Optional frame counter enabled by SPI_SENDER_FRAME_CNT_EN.
module spi_pixel_sender
    import ili9341_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int FRAME_PIX  = DISP_W * DISP_H
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_pixel_sender_if.slave    bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [PIX_IDX_W-1:0] pix_index
);

    localparam int GAP_W = cnt_w(GAP_CYCLES);

    if (CLK_DIV < 1 || GAP_CYCLES < 0 || FRAME_PIX < 1 || FRAME_PIX > (1 << PIX_IDX_W))
    begin : g_bad_params
        $error("spi_pixel_sender: illegal parameter value");
    end

    spi_sender_state_t  state, state_next;
    logic [PIXEL_W-1:0] shreg;
    logic [3:0]         bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               sck_q;
    logic               pix_ready;
    logic               sck_rise, sck_fall;
    logic               accept, word_done, gap_last;

    spi_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (state == ST_SHIFT),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    assign accept    = pix_ready && bus.pix_valid;
    assign word_done = (state == ST_SHIFT) && sck_fall && (bit_cnt == 4'd15);
    assign gap_last  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                pix_ready = !reset;
                if (accept) state_next = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: if (bus.spi_ready) state_next = ST_SHIFT;
            ST_SHIFT:    if (word_done) state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:      if (gap_last) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Next bit is presented on the same edge SCK falls; bit_cnt wraps only at word end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            sck_q   <= 1'b0;
        end else begin
            if (accept) shreg <= bus.pix_data;
            else if (state == ST_SHIFT && sck_fall) shreg <= {shreg[PIXEL_W-2:0], 1'b0};
            if (state == ST_SHIFT && sck_fall) bit_cnt <= bit_cnt + 4'd1;
            if (sck_rise)      sck_q <= 1'b1;
            else if (sck_fall) sck_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 gap_cnt <= '0;
        else if (state == ST_GAP)  gap_cnt <= gap_cnt + GAP_W'(1);
        else                       gap_cnt <= '0;
    end

    assign bus.pix_ready = pix_ready;
    assign bus.spi_sck   = sck_q;
    assign bus.spi_sda   = (state == ST_SHIFT) && shreg[PIXEL_W-1];

`ifdef SPI_SENDER_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_index  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (word_done) begin
                if (pix_index == PIX_IDX_W'(FRAME_PIX - 1)) begin
                    pix_index  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_index  <= pix_index + PIX_IDX_W'(1);
                end
            end
        end
    end
`else
    assign pix_index  = '0;
    assign frame_done = 1'b0;
`endif

endmodule
